// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion and arithmetic stages.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ceil(wid * log10(2)) using a fixed-point approximation of log10(2).
    function automatic int min_digits(input int wid);
        return (wid * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_dabble_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_dabble_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bcd_bin_to_bcd_seq.sv
// Sequential binary to packed-BCD converter, one double-dabble step per clock,
// with valid/ready on both sides and optional two's-complement input.
module bcd_bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WID    = 64,
    parameter int DIG    = 20,
    parameter bit SIGNED = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [WID-1:0]             i_bin,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [DIG*BCD_DIGIT_W-1:0] o_bcd,
    output logic                       o_neg,
    output logic                       o_ovf,
    output state_e                     dbg_state_o
);

    localparam int BW = DIG * BCD_DIGIT_W;
    localparam int CW = $clog2(WID);

    if (DIG < 1) begin : g_dig_chk
        $error("bcd_bin_to_bcd_seq: DIG must be at least 1");
    end
    if (DIG < min_digits(WID)) begin : g_dig_warn
        $warning("bcd_bin_to_bcd_seq: DIG is below the digits needed for WID, o_ovf can assert");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WID-1:0]  bin_q, bin_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;

    logic [BW-1:0]   adj;
    logic            accept;
    logic            in_neg;
    logic [WID-1:0]  in_mag;

    for (genvar g = 0; g < DIG; g++) begin : g_adj
        bcd_dabble_adj u_adj (
            .d_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Handshake: an operand transfers on any edge with i_valid && i_ready, a
    // result on any edge with o_valid && o_ready; both may happen on one edge.
    assign i_ready = (state_q == IDLE) || ((state_q == DONE) && o_ready);
    assign accept  = i_valid && i_ready;
    assign in_neg  = SIGNED && i_bin[WID-1];
    assign in_mag  = in_neg ? (~i_bin) + WID'(1) : i_bin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: ;
            SHIFT: begin
                bcd_d = {adj[BW-2:0], bin_q[WID-1]};
                bin_d = {bin_q[WID-2:0], 1'b0};
                ovf_d = ovf_q | adj[BW-1];
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                if (o_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new operand can only arrive in IDLE or while DONE is being drained.
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = CW'(WID - 1);
            bin_d   = in_mag;
            bcd_d   = '0;
            neg_d   = in_neg;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid     = (state_q == DONE);
    assign o_bcd       = bcd_q;
    assign o_neg       = neg_q;
    assign o_ovf       = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_bin_to_bcd_seq.sv
// Bench for bcd_bin_to_bcd_seq: an 8-bit unsigned converter plus signed and
// unsigned 64-bit converters sharing one input stream, each against a decimal model.
module tb_bcd_bin_to_bcd_seq;
    import bcd_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // ---------------- DUTs ----------------
    logic        a_iv = 1'b0, a_or = 1'b1, a_ir, a_ov, a_neg, a_ovf;
    logic [7:0]  a_bin = '0;
    logic [11:0] a_bcd;
    state_e      a_st;

    logic        w_iv = 1'b0, w_or = 1'b1;
    logic [63:0] w_bin = '0;
    logic        b_ir, b_ov, b_neg, b_ovf, c_ir, c_ov, c_neg, c_ovf;
    logic [79:0] b_bcd, c_bcd;
    state_e      b_st, c_st;

    bcd_bin_to_bcd_seq #(.WID(8), .DIG(3), .SIGNED(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .i_valid(a_iv), .i_ready(a_ir), .i_bin(a_bin),
        .o_valid(a_ov), .o_ready(a_or), .o_bcd(a_bcd), .o_neg(a_neg), .o_ovf(a_ovf),
        .dbg_state_o(a_st));

    bcd_bin_to_bcd_seq #(.WID(64), .DIG(20), .SIGNED(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst), .i_valid(w_iv), .i_ready(b_ir), .i_bin(w_bin),
        .o_valid(b_ov), .o_ready(w_or), .o_bcd(b_bcd), .o_neg(b_neg), .o_ovf(b_ovf),
        .dbg_state_o(b_st));

    bcd_bin_to_bcd_seq #(.WID(64), .DIG(20), .SIGNED(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst), .i_valid(w_iv), .i_ready(c_ir), .i_bin(w_bin),
        .o_valid(c_ov), .o_ready(w_or), .o_bcd(c_bcd), .o_neg(c_neg), .o_ovf(c_ovf),
        .dbg_state_o(c_st));

    // ---------------- model ----------------
    // Result packed as {neg, ovf, bcd[79:0]}; digits by repeated division by ten.
    function automatic logic [81:0] model(input logic [63:0] v, input bit sgn, input int dig);
        logic [63:0] x;
        logic [79:0] r;
        logic        n;
        n = sgn && v[63];
        x = n ? -v : v;
        r = '0;
        for (int i = 0; i < dig; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {n, (x != 0), r};
    endfunction

    task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [81:0] exp_q[3][$];
    int          acc_q[3][$];

    task automatic chan_step(input int ch, input int wid, input string nm,
                             input logic iv, input logic ir, input logic ov, input logic ordy,
                             input logic [81:0] act, input logic rst_now,
                             input logic [81:0] exp_new);
        logic exp_ov, exp_ir;
        exp_ov = (exp_q[ch].size() > 0) && ((cyc - acc_q[ch][0]) >= wid);
        exp_ir = (exp_q[ch].size() == 0) || (exp_ov && ordy);
        chk({nm, "_o_valid"}, 82'(ov), 82'(exp_ov));
        chk({nm, "_i_ready"}, 82'(ir), 82'(exp_ir));
        if (exp_ov && ov) chk({nm, "_result"}, act, exp_q[ch][0]);
        if (rst_now) begin
            exp_q[ch].delete();
            acc_q[ch].delete();
        end else begin
            if (exp_ov && ordy) begin
                void'(exp_q[ch].pop_front());
                void'(acc_q[ch].pop_front());
            end
            if (iv && exp_ir) begin
                exp_q[ch].push_back(exp_new);
                acc_q[ch].push_back(cyc + 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chan_step(0, 8, "a", a_iv, a_ir, a_ov, a_or, {a_neg, a_ovf, 80'(a_bcd)}, rst,
                      model({56'b0, a_bin}, 1'b0, 3));
            chan_step(1, 64, "b", w_iv, b_ir, b_ov, w_or, {b_neg, b_ovf, b_bcd}, rst,
                      model(w_bin, 1'b1, 20));
            chan_step(2, 64, "c", w_iv, c_ir, c_ov, w_or, {c_neg, c_ovf, c_bcd}, rst,
                      model(w_bin, 1'b0, 20));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_a(input logic [7:0] v);
        int n = 0;
        a_iv = 1'b1; a_bin = v;
        do begin @(negedge clk); n++; end while (!a_ir && n < 200);
        if (!a_ir) chk("a_accept_timeout", 82'(a_ir), 82'd1);
        @(posedge clk); #1;
        a_iv = 1'b0; a_bin = 8'($urandom);
    endtask

    task automatic send_w(input logic [63:0] v);
        int n = 0;
        w_iv = 1'b1; w_bin = v;
        do begin @(negedge clk); n++; end while (!b_ir && n < 200);
        if (!b_ir) chk("w_accept_timeout", 82'(b_ir), 82'd1);
        @(posedge clk); #1;
        w_iv = 1'b0; w_bin = {$urandom, $urandom};
    endtask

    task automatic wait_a_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!a_ov && n < 200);
        if (!a_ov) chk("a_valid_timeout", 82'(a_ov), 82'd1);
    endtask

    task automatic wait_w_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!(b_ov && c_ov) && n < 200);
        if (!(b_ov && c_ov)) chk("w_valid_timeout", 82'({b_ov, c_ov}), 82'd3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [81:0] m;

        // Hand-computed values pinning the model.
        m = model(64'd255, 1'b0, 3);        chk("pin_255", m, {2'b00, 80'h255});
        m = model('1, 1'b0, 20);            chk("pin_max64", m, {2'b00, 80'h18446744073709551615});
        m = model('1, 1'b1, 20);            chk("pin_minus1", m, {2'b10, 80'h1});
        m = model(64'h8000_0000_0000_0000, 1'b1, 20);
        chk("pin_minint", m, {2'b10, 80'h09223372036854775808});
        m = model(64'd100, 1'b0, 2);        chk("pin_ovf100", m, {2'b01, 80'h00});
        m = model(64'd99, 1'b0, 2);         chk("pin_99", m, {2'b00, 80'h99});
        m = model(64'd0, 1'b1, 20);         chk("pin_zero_s", m, 82'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_a_state", 82'(a_st), 82'(IDLE));
        chk("rst_a_ready", 82'(a_ir), 82'd1);
        chk("rst_a_outs", {a_ov, a_neg, a_ovf, 12'(a_bcd)}, 82'd0);
        chk("rst_b_outs", {b_ov, b_neg, b_ovf, b_bcd}, 82'd0);
        chk("rst_c_state", 82'(c_st), 82'(IDLE));
        @(posedge clk); #1;

        // Directed 8-bit conversions.
        send_a(8'd255); wait_a_valid();
        chk("a_255", {a_ovf, 12'(a_bcd)}, {1'b0, 12'h255});
        @(posedge clk); #1;
        send_a(8'd0); wait_a_valid();
        chk("a_0", {a_ovf, 12'(a_bcd)}, 82'h000);
        @(posedge clk); #1;

        // Directed 64-bit conversions, signed (b) and unsigned (c).
        send_w('1); wait_w_valid();
        chk("c_max64", {c_neg, c_ovf, c_bcd}, {2'b00, 80'h18446744073709551615});
        chk("b_minus1", {b_neg, b_ovf, b_bcd}, {2'b10, 80'h1});
        chk("b_state_done", 82'(b_st), 82'(DONE));
        @(posedge clk); #1;
        send_w(64'h8000_0000_0000_0000); wait_w_valid();
        chk("b_minint", {b_neg, b_ovf, b_bcd}, {2'b10, 80'h09223372036854775808});
        chk("c_2pow63", {c_neg, c_ovf, c_bcd}, {2'b00, 80'h09223372036854775808});
        @(posedge clk); #1;
        send_w(64'd0); wait_w_valid();
        chk("b_zero", {b_neg, b_ovf, b_bcd}, 82'd0);
        @(posedge clk); #1;

        // Backpressure in DONE, then drain and accept on the same edge.
        a_or = 1'b0;
        send_a(8'd77); wait_a_valid();
        chk("bp_first", 82'(a_bcd), 82'h077);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            a_iv = 1'b1; a_bin = 8'($urandom);
            @(negedge clk);
            chk("bp_ready", 82'(a_ir), 82'd0);
            chk("bp_hold", {a_ov, a_neg, a_ovf, a_bcd}, {1'b1, 2'b00, 12'h077});
            @(posedge clk); #1;
        end
        a_or = 1'b1; a_bin = 8'd200;
        @(negedge clk);
        chk("b2b_ready", 82'(a_ir), 82'd1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        @(negedge clk);
        chk("b2b_no_bubble", 82'(a_st), 82'(SHIFT));
        wait_a_valid();
        chk("b2b_200", 82'(a_bcd), 82'h200);
        @(posedge clk); #1;

        // Reset in the middle of a conversion.
        send_a(8'd123);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", 82'(a_st), 82'(IDLE));
        chk("mid_rst_ready", 82'(a_ir), 82'd1);
        chk("mid_rst_outs", {a_ov, a_neg, a_ovf, a_bcd}, 82'd0);
        @(posedge clk); #1;
        send_a(8'd42); wait_a_valid();
        chk("after_rst_42", 82'(a_bcd), 82'h042);
        @(posedge clk); #1;

        // Randomized traffic; the scoreboard checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            a_iv  = ($urandom_range(0, 3) != 0);
            a_bin = 8'($urandom);
            a_or  = ($urandom_range(0, 2) != 0);
            w_iv  = ($urandom_range(0, 3) != 0);
            w_or  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       w_bin = '0;
                1:       w_bin = '1;
                2:       w_bin = 64'h8000_0000_0000_0000;
                3:       w_bin = 64'($urandom_range(0, 999));
                default: w_bin = {$urandom, $urandom};
            endcase
            @(posedge clk); #1;
        end
        a_iv = 1'b0; w_iv = 1'b0; a_or = 1'b1; w_or = 1'b1;
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("drain_a", 82'(exp_q[0].size()), 82'd0);
        chk("drain_b", 82'(exp_q[1].size()), 82'd0);
        chk("drain_c", 82'(exp_q[2].size()), 82'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
